// File: rtl/mux_4x1_rr_pkg.sv
// Shared definitions for the four-lane round-robin channel combiner.
// Holds the FSM encoding, lane geometry and the pointer arithmetic helper.
package mux_4x1_rr_pkg;

  localparam int LANES = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  // Lane index arithmetic wraps naturally at SEL_W bits.
  function automatic logic [SEL_W-1:0] lane_add(input logic [SEL_W-1:0] base,
                                                input int unsigned      off);
    return base + SEL_W'(off);
  endfunction

endpackage

// File: rtl/mux_4x1_rr_arb.sv
// Four-requester round-robin arbiter, purely combinational.
// Search starts at the lane after i_last and wraps; the grant is gated by i_en.
module rr_arb_4
  import mux_4x1_rr_pkg::*;
(
  input  logic [LANES-1:0] i_req,
  input  logic [SEL_W-1:0] i_last,
  input  logic             i_en,
  output logic [LANES-1:0] o_gnt,
  output logic [SEL_W-1:0] o_idx
);

  logic             w_found;
  logic [SEL_W-1:0] w_cand;

  // NOTE: every signal written in a combinational block gets a default first,
  // so no path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    w_found = 1'b0;
    w_cand  = '0;
    o_idx   = '0;
    o_gnt   = '0;
    for (int unsigned off = 1; off <= LANES; off++) begin
      w_cand = lane_add(i_last, off);
      if (!w_found && i_req[w_cand]) begin
        w_found = 1'b1;
        o_idx   = w_cand;
      end
    end
    if (i_en && w_found) o_gnt[o_idx] = 1'b1;
  end

endmodule

// File: rtl/mux_4x1_rr.sv
// Four-source to one-sink valid/ready combiner with round-robin arbitration.
// The winning word and its lane index are held in a single output register.
module mux_4x1_rr
  import mux_4x1_rr_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              in_clk,
  input  logic              in_rst_n,
  input  logic [DATA_W-1:0] in_d_1,
  input  logic [DATA_W-1:0] in_d_2,
  input  logic [DATA_W-1:0] in_d_3,
  input  logic [DATA_W-1:0] in_d_4,
  input  logic              in_v_1,
  input  logic              in_v_2,
  input  logic              in_v_3,
  input  logic              in_v_4,
  output logic              out_rdy_1,
  output logic              out_rdy_2,
  output logic              out_rdy_3,
  output logic              out_rdy_4,
  output logic [DATA_W-1:0] out_y,
  output logic [SEL_W-1:0]  out_sel,
  output logic              out_v,
  input  logic              in_rdy
);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [SEL_W-1:0]  r_last;
  logic [DATA_W-1:0] r_y;
  logic [SEL_W-1:0]  r_sel;

  logic [LANES-1:0]  w_req;
  logic [LANES-1:0]  w_gnt;
  logic [SEL_W-1:0]  w_idx;
  logic              w_ld;
  logic              w_xfer;
  logic [DATA_W-1:0] w_d_sel;

  assign w_req = {in_v_4, in_v_3, in_v_2, in_v_1};

  // Grants are suppressed while reset is asserted so no source sees a
  // handshake that the register will never capture.
  assign w_ld = in_rst_n && ((r_state == ST_EMPTY) || in_rdy);

  rr_arb_4 u_arb (
    .i_req  (w_req),
    .i_last (r_last),
    .i_en   (w_ld),
    .o_gnt  (w_gnt),
    .o_idx  (w_idx)
  );

  // A grant is only ever issued to a lane that is currently valid.
  assign w_xfer = |w_gnt;

  assign {out_rdy_4, out_rdy_3, out_rdy_2, out_rdy_1} = w_gnt;

  always_comb begin
    w_d_sel = in_d_1;
    case (w_idx)
      2'd1:    w_d_sel = in_d_2;
      2'd2:    w_d_sel = in_d_3;
      2'd3:    w_d_sel = in_d_4;
      default: w_d_sel = in_d_1;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: if (w_xfer) w_state_nxt = ST_FULL;
      ST_FULL:  if (in_rdy && !w_xfer) w_state_nxt = ST_EMPTY;
      default:  w_state_nxt = ST_EMPTY;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      r_state <= ST_EMPTY;
      r_last  <= SEL_W'(LANES - 1);
      r_y     <= '0;
      r_sel   <= '0;
    end else begin
      r_state <= w_state_nxt;
      // Pointer and payload move only on a source transfer; an idle or
      // drain cycle leaves them untouched.
      if (w_xfer) begin
        r_last <= w_idx;
        r_y    <= w_d_sel;
        r_sel  <= w_idx;
      end
    end
  end

  // Output valid is decoded straight from the state register, keeping
  // in_rdy off any combinational path to out_v or out_y.
  assign out_v   = (r_state == ST_FULL);
  assign out_y   = r_y;
  assign out_sel = r_sel;

endmodule

// File: tb/tb_mux_4x1_rr.sv
// Directed self-checking bench for mux_4x1_rr: reset, single lane, round-robin,
// backpressure, wrap/skip and asynchronous reset mid-stream.
module tb_mux_4x1_rr;

  logic       in_clk;
  logic       in_rst_n;
  logic [7:0] in_d_1, in_d_2, in_d_3, in_d_4;
  logic       in_v_1, in_v_2, in_v_3, in_v_4;
  logic       out_rdy_1, out_rdy_2, out_rdy_3, out_rdy_4;
  logic [7:0] out_y;
  logic [1:0] out_sel;
  logic       out_v;
  logic       in_rdy;

  int n_checks = 0;
  int n_pass   = 0;

  logic [3:0] w_rdy;
  assign w_rdy = {out_rdy_4, out_rdy_3, out_rdy_2, out_rdy_1};

  mux_4x1_rr #(.DATA_W(8)) dut (
    .in_clk    (in_clk),
    .in_rst_n  (in_rst_n),
    .in_d_1    (in_d_1),
    .in_d_2    (in_d_2),
    .in_d_3    (in_d_3),
    .in_d_4    (in_d_4),
    .in_v_1    (in_v_1),
    .in_v_2    (in_v_2),
    .in_v_3    (in_v_3),
    .in_v_4    (in_v_4),
    .out_rdy_1 (out_rdy_1),
    .out_rdy_2 (out_rdy_2),
    .out_rdy_3 (out_rdy_3),
    .out_rdy_4 (out_rdy_4),
    .out_y     (out_y),
    .out_sel   (out_sel),
    .out_v     (out_v),
    .in_rdy    (in_rdy)
  );

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance past the next rising edge; inputs change and outputs are
  // sampled 1 time unit after the edge, well away from it.
  task automatic tick();
    @(posedge in_clk);
    #1;
  endtask

  task automatic set_v(input logic [3:0] v);
    {in_v_4, in_v_3, in_v_2, in_v_1} = v;
    #1;
  endtask

  task automatic check_out(input string tag, input logic [7:0] y, input logic [1:0] sel,
                           input logic v);
    check({tag, ".y"},   out_y,          y);
    check({tag, ".sel"}, 8'(out_sel),    8'(sel));
    check({tag, ".v"},   8'(out_v),      8'(v));
  endtask

  logic [7:0] rr_exp [8];

  initial begin
    rr_exp = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11, 8'h22, 8'h33, 8'h44};
    in_rst_n = 1'b0;
    in_d_1 = 8'h11; in_d_2 = 8'h22; in_d_3 = 8'h33; in_d_4 = 8'h44;
    in_rdy = 1'b1;
    set_v(4'b1111);

    // Reset held with every lane valid: nothing granted, outputs cleared.
    tick(); tick();
    check_out("rst", 8'h00, 2'd0, 1'b0);
    check("rst.rdy", 8'(w_rdy), 8'h00);

    // Release: lane 1 has top priority, then strict rotation at full rate.
    in_rst_n = 1'b1;
    #1;
    check("rel.rdy", 8'(w_rdy), 8'h01);
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("rr%0d.y", i), out_y, rr_exp[i]);
      check($sformatf("rr%0d.v", i), 8'(out_v), 8'h01);
    end

    // Single lane 3 after last=lane 4.
    in_d_3 = 8'hA5;
    set_v(4'b0100);
    check("single.rdy", 8'(w_rdy), 8'h04);
    tick();
    check_out("single", 8'hA5, 2'd2, 1'b1);

    // Drain with no valid: out_v drops, payload and index held.
    set_v(4'b0000);
    check("drain.rdy", 8'(w_rdy), 8'h00);
    tick();
    check_out("drain", 8'hA5, 2'd2, 1'b0);
    tick();
    check("idle.v", 8'(out_v), 8'h00);

    // Backpressure: load lane 2 (0x22), then hold with all lanes valid.
    in_d_3 = 8'h33;
    set_v(4'b0010);
    check("bp_ld.rdy", 8'(w_rdy), 8'h02);
    tick();
    check_out("bp_ld", 8'h22, 2'd1, 1'b1);
    in_rdy = 1'b0;
    set_v(4'b1111);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp%0d.rdy", i), 8'(w_rdy), 8'h00);
      tick();
      check($sformatf("bp%0d.y", i), out_y, 8'h22);
      check($sformatf("bp%0d.v", i), 8'(out_v), 8'h01);
    end
    in_rdy = 1'b1;
    #1;
    check("bp_rel.rdy", 8'(w_rdy), 8'h04);
    tick();
    check_out("bp_rel", 8'h33, 2'd2, 1'b1);

    // Wrap and skip: make lane 4 the last grant, then only lane 2 valid.
    set_v(4'b1000);
    tick();
    check_out("wrap4", 8'h44, 2'd3, 1'b1);
    set_v(4'b0010);
    check("wrap.rdy", 8'(w_rdy), 8'h02);
    tick();
    check_out("wrap", 8'h22, 2'd1, 1'b1);
    set_v(4'b0011);
    check("skip.rdy", 8'(w_rdy), 8'h01);
    tick();
    check_out("skip", 8'h11, 2'd0, 1'b1);

    // Asynchronous reset mid-stream while FULL and stalled.
    in_rdy = 1'b0;
    set_v(4'b1111);
    check("pre_rst.v", 8'(out_v), 8'h01);
    #1;
    in_rst_n = 1'b0;
    #1;
    check("arst.v", 8'(out_v), 8'h00);
    check("arst.y", out_y, 8'h00);
    #1;
    in_rst_n = 1'b1;
    #1;
    check("arst_rel.rdy", 8'(w_rdy), 8'h01);
    tick();
    check_out("arst_rel", 8'h11, 2'd0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mux_4x1_rr.md
Name: mux_4x1_rr

Overview:
- Four-source to one-sink channel combiner with valid/ready handshakes; the gathering counterpart of the 1x4 data demultiplexer tree.
- Round-robin arbitration among four producers; the winning word is captured into a single output register with its source index.
- Sits where four demuxed lanes reconverge onto one shared consumer.

Parameters:
- DATA_W, 8, width of each data word.

Ports:
- in_clk  input  1  clock; all state on rising edge.
- in_rst_n  input  1  asynchronous active-low reset.
- in_d_1, in_d_2, in_d_3, in_d_4  input  DATA_W  source data words, lanes 1..4.
- in_v_1, in_v_2, in_v_3, in_v_4  input  1  source valid, lanes 1..4.
- out_rdy_1, out_rdy_2, out_rdy_3, out_rdy_4  output  1  grant/ready back to each source (combinational).
- out_y  output  DATA_W  registered output word.
- out_sel  output  2  registered lane index of out_y (0 = lane 1 .. 3 = lane 4).
- out_v  output  1  registered output valid.
- in_rdy  input  1  sink ready.

Behaviour:
- Reset (asynchronous, in_rst_n low): out_v=0, out_y=0, out_sel=0, last-grant pointer=3 so lane 1 has top priority first; FSM=EMPTY. Release is synchronous to in_clk.
- FSM states: EMPTY (out_v=0) and FULL (out_v=1).
- Load enable: ld = (state==EMPTY) or (state==FULL and in_rdy).
- Arbitration (combinational):
  - Search order starts at lane (last+1) mod 4 and wraps.
  - The first lane with in_v_k=1 wins.
  - Exactly one out_rdy_k is high, for the winner, and only when ld=1 and at least one valid is present. Otherwise all out_rdy_k=0.
- Transfer on lane k: in_v_k and out_rdy_k both high at a rising edge. Then out_y<=in_d_k, out_sel<=k-1, out_v<=1, last<=k-1.
- Sink transfer: out_v and in_rdy both high at a rising edge.
- Transitions:
  - EMPTY, no valid: stay EMPTY.
  - EMPTY, any valid: load, go FULL. Latency is 1 cycle from source transfer to out_v.
  - FULL, in_rdy=0: hold out_y, out_sel, out_v stable. No grants.
  - FULL, in_rdy=1, a valid present: sink consume and new load in the same edge, stay FULL. Sustained throughput is 1 word/cycle.
  - FULL, in_rdy=1, no valid: go EMPTY, out_v<=0. out_y and out_sel keep their last value.
- Pointer updates only on a source transfer, never on an idle cycle.
- Fairness: with all four lanes continuously valid and in_rdy=1, grants cycle 1,2,3,4,1,... Each lane waits at most 3 grants.
- Sources must hold in_d_k and in_v_k stable until granted. The block does not depend on in_v dropping without a grant; a dropped request is simply skipped.
- Reset mid-operation: any held word is discarded, out_v=0 immediately, pointer returns to 3.
- No combinational path from in_rdy to out_y or out_v. out_rdy_k depends combinationally on in_rdy and all in_v.

Decomposition:
- Shared package: localparams for the FSM state encodings (ST_EMPTY=0, ST_FULL=1) and LANES=4, SEL_W=2.
- One natural sub-module: rr_arb_4.
  - Inputs: 4-bit request vector, 2-bit last pointer, enable.
  - Outputs: one-hot 4-bit grant, 2-bit encoded index.
  - Purely combinational.
- Top level holds the FSM, pointer, output register and data select.

Test Plan:
- Reset: hold in_rst_n=0 with all in_v_k=1 -> out_v=0, out_y=0, out_sel=0, all out_rdy_k=0. First edge after release grants lane 1.
- Single lane: in_v_3=1, in_d_3=8'hA5, in_rdy=1 -> out_rdy_3=1 that cycle; next cycle out_y=8'hA5, out_sel=2, out_v=1.
- Round-robin: all lanes valid with data 8'h11/22/33/44, in_rdy=1 for 8 cycles -> out_y sequence 11,22,33,44,11,22,33,44 with out_v continuously 1.
- Backpressure: FULL with out_y=8'h22, in_rdy=0 for 5 cycles while all lanes valid -> out_y stays 22, all out_rdy_k=0. When in_rdy rises, the next grant is lane 3.
- Wrap and skip: last=lane 4, only in_v_2=1 -> lane 2 granted, out_sel=1. Then in_v_1 and in_v_2 both valid -> lane 3 and lane 4 are skipped, lane 1 wins.
- Reset mid-stream: assert in_rst_n=0 while out_v=1 and in_rdy=0 -> out_v falls without waiting for in_clk. After release, lane 1 has priority again.
